// File: rtl/dlfloat_dot_acc.sv
// rtl/dlfloat_dot_acc.sv - pipelined DLFloat16 dot-product accumulator with valid/ready flow control
// Optional DLFLOAT_SAT_EN: saturate/flush out-of-range exponents instead of wrapping modulo 64.
module dlfloat_dot_acc #(
    parameter int ACC_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    function automatic logic [15:0] fp_pack(input logic s, input logic signed [9:0] e,
                                            input logic [8:0] m);
        logic unused_hi;
        unused_hi = ^e[9:6];
`ifdef DLFLOAT_SAT_EN
        if (e > 10'sd62) return s ? 16'hFDFF : 16'h7DFF;
        if (e < 10'sd1) return 16'h0000;
`endif
        return {s, e[5:0], m};
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic [19:0]       prod;
        logic signed [9:0] e;
        logic [8:0]        m;
        logic              unused_lo;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        prod = {1'b1, a[8:0]} * {1'b1, b[8:0]};
        unused_lo = ^prod[8:0];
        e = $signed({4'b0, a[14:9]}) + $signed({4'b0, b[14:9]}) - 10'sd31;
        if (prod[19]) begin
            e = e + 10'sd1;
            m = prod[18:10];
        end else begin
            m = prod[17:9];
        end
        return fp_pack(a[15] ^ b[15], e, m);
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0]       big, sml;
        logic [10:0]       mb, ms, sum;
        logic [5:0]        d;
        logic signed [9:0] e;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        if (x[14:0] >= y[14:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d   = big[14:9] - sml[14:9];
        mb  = {2'b01, big[8:0]};
        ms  = {2'b01, sml[8:0]} >> d;
        sum = (big[15] == sml[15]) ? mb + ms : mb - ms;
        if (sum == 11'd0) return 16'h0000;
        e = $signed({4'b0, big[14:9]});
        if (sum[10]) begin
            sum = sum >> 1;
            e   = e + 10'sd1;
        end else begin
            // leading-one search: at most nine shifts bring bit 9 up
            for (int i = 0; i < 9; i++) begin
                if (!sum[9]) begin
                    sum = sum << 1;
                    e   = e - 10'sd1;
                end
            end
        end
        return fp_pack(big[15], e, sum[8:0]);
    endfunction

    logic        stall;
    logic [15:0] p;
    logic        p_vld;
    logic        p_last;
    logic [15:0] acc;
    logic        first;
    logic [15:0] acc_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clr;
    assign acc_next = first ? p : fp_add(acc, p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            p         <= 16'h0000;
            p_vld     <= 1'b0;
            p_last    <= 1'b0;
            acc       <= 16'h0000;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (clr) begin
            beat_cnt  <= '0;
            p_vld     <= 1'b0;
            first     <= 1'b1;
            out_valid <= 1'b0;
        end else if (!stall) begin
            p_vld <= in_valid;
            if (in_valid) begin
                p        <= fp_mul(in_a, in_b);
                p_last   <= (beat_cnt == LAST);
                beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
            end
            // not stalled means any held result is being taken this edge
            out_valid <= p_vld & p_last;
            if (p_vld) begin
                if (p_last) begin
                    out_data <= acc_next;
                    first    <= 1'b1;
                end else begin
                    acc   <= acc_next;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dlfloat_dot_acc.sv
// tb/tb_dlfloat_dot_acc.sv - directed plus randomized bench for dlfloat_dot_acc against an integer reference model
module tb_dlfloat_dot_acc;
    localparam int ACC_LEN = 4;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] beat_cnt;

    dlfloat_dot_acc #(.ACC_LEN(ACC_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic        last_fire;
    logic [15:0] last_out;
    logic [31:0] beats[$];
    logic [15:0] exp_val[$];
    int          exp_avail[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic on plain integers: significands as 512..1023, exponents unbounded ints.
    function automatic logic [15:0] m_pack(input int s, input int e, input int frac);
`ifdef DLFLOAT_SAT_EN
        if (e > 62) return (s != 0) ? 16'hFDFF : 16'h7DFF;
        if (e < 1) return 16'h0000;
`endif
        return 16'(s * 32768 + (((e % 64) + 64) % 64) * 512 + frac);
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        int ia, ib, sig, e, s;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        ia  = int'(a);
        ib  = int'(b);
        s   = (ia / 32768 + ib / 32768) % 2;
        sig = (512 + ia % 512) * (512 + ib % 512);
        e   = (ia / 512) % 64 + (ib / 512) % 64 - 31;
        if (sig >= 524288) return m_pack(s, e + 1, (sig / 1024) % 512);
        return m_pack(s, e, (sig / 512) % 512);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
        int big, sml, eb, d, mb, ms, r, e;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        if (int'(x) % 32768 >= int'(y) % 32768) begin
            big = int'(x);
            sml = int'(y);
        end else begin
            big = int'(y);
            sml = int'(x);
        end
        eb = (big / 512) % 64;
        d  = eb - (sml / 512) % 64;
        mb = 512 + big % 512;
        ms = (d >= 10) ? 0 : (512 + sml % 512) / (1 << d);
        r  = (big / 32768 == sml / 32768) ? mb + ms : mb - ms;
        if (r == 0) return 16'h0000;
        e = eb;
        if (r >= 1024) begin
            r = r / 2;
            e++;
        end
        while (r < 512) begin
            r = r * 2;
            e--;
        end
        return m_pack(big / 32768, e, r - 512);
    endfunction

    function automatic logic [15:0] m_fold();
        logic [15:0] acc;
        acc = m_mul(beats[0][31:16], beats[0][15:0]);
        for (int i = 1; i < beats.size(); i++)
            acc = m_add(acc, m_mul(beats[i][31:16], beats[i][15:0]));
        return acc;
    endfunction

    task automatic model_clear();
        beats.delete();
        exp_val.delete();
        exp_avail.delete();
    endtask

    // One clock: inputs already driven at the preceding negedge; sample, check, advance.
    task automatic cycle();
        logic ev, er;
        #1;
        ev = (exp_val.size() > 0) && (exp_avail[0] <= cyc);
        er = !clr && !(ev && !out_ready);
        chk("in_ready", 16'(in_ready), 16'(er));
        chk("out_valid", 16'(out_valid), 16'(ev));
        chk("beat_cnt", 16'(beat_cnt), 16'(beats.size()));
        if (ev) chk("out_data", out_data, exp_val[0]);
        last_fire = in_valid && er;
        if (clr) begin
            model_clear();
        end else begin
            if (ev && out_ready) begin
                last_out = out_data;
                n_out++;
                void'(exp_val.pop_front());
                void'(exp_avail.pop_front());
                if (exp_avail.size() > 0 && exp_avail[0] < cyc + 1) exp_avail[0] = cyc + 1;
            end
            if (last_fire) begin
                beats.push_back({in_a, in_b});
                if (beats.size() == ACC_LEN) begin
                    exp_val.push_back(m_fold());
                    exp_avail.push_back(cyc + 2);
                    beats.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        last_fire = 1'b0;
        while (!last_fire && n < 40) begin
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", 16'(last_fire), 16'h0001);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    function automatic logic [15:0] rnd_op();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        if (r == 2) return {1'($urandom_range(0, 1)), 6'($urandom_range(55, 62)), 9'($urandom_range(0, 511))};
        return {1'($urandom_range(0, 1)), 6'($urandom_range(26, 36)), 9'($urandom_range(0, 511))};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          n;
        logic [15:0] sat_exp;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_beat_cnt", 16'(beat_cnt), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        last_out = 16'hDEAD;
        repeat (4) send(16'h3E00, 16'h4000);
        drain(4);
        chk("sum_8", last_out, 16'h4400);

        last_out = 16'hDEAD;
        repeat (2) begin
            send(16'h3E00, 16'h3E00);
            send(16'hBE00, 16'h3E00);
        end
        drain(4);
        chk("cancel", last_out, 16'h0000);

        last_out = 16'hDEAD;
        send(16'h3E00, 16'h3E00);
        send(16'hFFFF, 16'h3E00);
        send(16'h3E00, 16'h3E00);
        send(16'h3E00, 16'h3E00);
        drain(4);
        chk("nan_sticky", last_out, 16'hFFFF);

`ifdef DLFLOAT_SAT_EN
        sat_exp = 16'h7DFF;
`else
        sat_exp = 16'h3600;
`endif
        last_out = 16'hDEAD;
        send(16'h7A00, 16'h7A00);
        repeat (3) send(16'h0000, 16'h3E00);
        drain(4);
        chk("exp_range", last_out, sat_exp);

        n0 = n_out;
        out_ready = 1'b0;
        repeat (4) send(16'h3E00, 16'h4000);
        in_valid = 1'b1;
        in_a = 16'h3F00;
        in_b = 16'h4000;
        repeat (2) cycle();
        repeat (5) begin
            #1;
            chk("stall_in_ready", 16'(in_ready), 16'h0000);
            chk("stall_hold", out_data, 16'h4400);
            cycle();
        end
        out_ready = 1'b1;
        n = 0;
        while (n_out < n0 + 2 && n < 40) begin
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("stall_results", 16'(n_out - n0), 16'h0002);
        chk("stall_second", last_out, 16'h4500);

        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n0 = n_out;
        send(16'h3E00, 16'h4000);
        send(16'h3E00, 16'h4000);
        clr = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("clr_in_ready", 16'(in_ready), 16'h0000);
        cycle();
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_beat_cnt", 16'(beat_cnt), 16'h0000);
        last_out = 16'hDEAD;
        repeat (4) send(16'h3E00, 16'h4000);
        drain(4);
        chk("clr_fresh", last_out, 16'h4400);
        chk("clr_one_result", 16'(n_out - n0), 16'h0001);

        send(16'h3E00, 16'h4000);
        send(16'h3E00, 16'h4000);
        rst_n = 1'b0;
        #1;
        chk("arst_beat_cnt", 16'(beat_cnt), 16'h0000);
        chk("arst_out_valid", 16'(out_valid), 16'h0000);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        last_out = 16'hDEAD;
        repeat (4) send(16'h3E00, 16'h4000);
        drain(4);
        chk("arst_fresh", last_out, 16'h4400);

        repeat (400) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) < 2);
            in_a = rnd_op();
            in_b = rnd_op();
            cycle();
        end
        clr = 1'b0;
        drain(8);
        chk("rand_drained", 16'(exp_val.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
